// File: rtl/control_sequencer.sv
// Hardwired control unit for the single-bus CPU datapath.
// A T-state counter advances one step per clock. Every control strobe is
// decoded combinationally from the registered state together with the
// opcode, which the datapath holds stable from T3 onwards. CON_FF is also
// used, but only in the branch T6 step.
module control_sequencer #(
  parameter int OPW = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IR,
  input  logic        CON_FF,
  output logic        HIout,
  output logic        LOout,
  output logic        Zhighout,
  output logic        Zlowout,
  output logic        PCout,
  output logic        MDRout,
  output logic        INout,
  output logic        Cout,
  output logic        HIin,
  output logic        LOin,
  output logic        PCin,
  output logic        IRin,
  output logic        Zin,
  output logic        Yin,
  output logic        MARin,
  output logic        MDRin,
  output logic        CONin,
  output logic        OUT_Portin,
  output logic        Read,
  output logic        read_mem,
  output logic        write_mem,
  output logic        IncPC,
  output logic        PCSave,
  output logic        CON_RESET,
  output logic        AND,
  output logic        OR,
  output logic        ADD,
  output logic        SUB,
  output logic        MUL,
  output logic        DIV,
  output logic        SHR,
  output logic        SHRA,
  output logic        SHL,
  output logic        ROR,
  output logic        ROL,
  output logic        NEG,
  output logic        NOT,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        Run
);

  typedef enum logic [3:0] {
    S_RST  = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_T7   = 4'd8,
    S_HALT = 4'd9
  } state_e;

  typedef struct packed {
    logic and_op;
    logic or_op;
    logic add_op;
    logic sub_op;
    logic mul_op;
    logic div_op;
    logic shr_op;
    logic shra_op;
    logic shl_op;
    logic ror_op;
    logic rol_op;
    logic neg_op;
    logic not_op;
  } alu_t;

  localparam logic [OPW-1:0] OP_LD   = 5'b00000;
  localparam logic [OPW-1:0] OP_LDI  = 5'b00001;
  localparam logic [OPW-1:0] OP_ST   = 5'b00010;
  localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPW-1:0] OP_AND  = 5'b00101;
  localparam logic [OPW-1:0] OP_OR   = 5'b00110;
  localparam logic [OPW-1:0] OP_ROR  = 5'b00111;
  localparam logic [OPW-1:0] OP_ROL  = 5'b01000;
  localparam logic [OPW-1:0] OP_SHR  = 5'b01001;
  localparam logic [OPW-1:0] OP_SHRA = 5'b01010;
  localparam logic [OPW-1:0] OP_SHL  = 5'b01011;
  localparam logic [OPW-1:0] OP_ADDI = 5'b01100;
  localparam logic [OPW-1:0] OP_ANDI = 5'b01101;
  localparam logic [OPW-1:0] OP_ORI  = 5'b01110;
  localparam logic [OPW-1:0] OP_MUL  = 5'b01111;
  localparam logic [OPW-1:0] OP_DIV  = 5'b10000;
  localparam logic [OPW-1:0] OP_NEG  = 5'b10001;
  localparam logic [OPW-1:0] OP_NOT  = 5'b10010;
  localparam logic [OPW-1:0] OP_BR   = 5'b10011;
  localparam logic [OPW-1:0] OP_JR   = 5'b10100;
  localparam logic [OPW-1:0] OP_JAL  = 5'b10101;
  localparam logic [OPW-1:0] OP_IN   = 5'b10110;
  localparam logic [OPW-1:0] OP_OUT  = 5'b10111;
  localparam logic [OPW-1:0] OP_MFHI = 5'b11000;
  localparam logic [OPW-1:0] OP_MFLO = 5'b11001;
  localparam logic [OPW-1:0] OP_NOP  = 5'b11010;
  localparam logic [OPW-1:0] OP_HALT = 5'b11011;

  // ALU select for the instruction's own operation (immediates map onto
  // their register-form op).
  function automatic alu_t alu_for(input logic [OPW-1:0] op);
    alu_t a;
    a = '0;
    case (op)
      OP_ADD, OP_ADDI: a.add_op  = 1'b1;
      OP_SUB:          a.sub_op  = 1'b1;
      OP_AND, OP_ANDI: a.and_op  = 1'b1;
      OP_OR, OP_ORI:   a.or_op   = 1'b1;
      OP_ROR:          a.ror_op  = 1'b1;
      OP_ROL:          a.rol_op  = 1'b1;
      OP_SHR:          a.shr_op  = 1'b1;
      OP_SHRA:         a.shra_op = 1'b1;
      OP_SHL:          a.shl_op  = 1'b1;
      OP_MUL:          a.mul_op  = 1'b1;
      OP_DIV:          a.div_op  = 1'b1;
      OP_NEG:          a.neg_op  = 1'b1;
      OP_NOT:          a.not_op  = 1'b1;
      default:         a = '0;
    endcase
    return a;
  endfunction

  state_e         state_q, state_d;
  state_e         last_s;
  alu_t           alu_s;
  logic [OPW-1:0] op_s;
  logic           unused_ir_s;

  assign op_s = IR[31 -: OPW];
  // Operand fields are consumed by the datapath's register-select logic.
  assign unused_ir_s = ^IR[31-OPW:0];

  // Final execute step of the current opcode; the step after it is T0.
  always_comb begin
    last_s = S_T3;
    case (op_s)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL,
      OP_ADDI, OP_ANDI, OP_ORI, OP_LDI: last_s = S_T5;
      OP_LD, OP_ST:                     last_s = S_T7;
      OP_MUL, OP_DIV, OP_BR:            last_s = S_T6;
      OP_NEG, OP_NOT, OP_JAL:           last_s = S_T4;
      default:                          last_s = S_T3;
    endcase
  end

  // State register; reset forces RST immediately, independent of the clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_RST;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: fetch T0-T2, then dispatch on opcode; HALT is left only by reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RST: state_d = S_T0;
      S_T0:  state_d = S_T1;
      S_T1:  state_d = S_T2;
      S_T2: begin
        if (op_s == OP_HALT) begin
          state_d = S_HALT;
        end else if ((op_s == OP_NOP) || (op_s[4:2] == 3'b111)) begin
          state_d = S_T0;
        end else begin
          state_d = S_T3;
        end
      end
      S_T3, S_T4, S_T5, S_T6: begin
        if (state_q == last_s) begin
          state_d = S_T0;
        end else begin
          state_d = state_e'(state_q + 4'd1);
        end
      end
      S_T7:   state_d = S_T0;
      S_HALT: state_d = S_HALT;
      default: state_d = S_RST;
    endcase
  end

  // Strobe decode: everything defaults low, each step raises only its own set.
  always_comb begin
    HIout = 1'b0; LOout = 1'b0; Zhighout = 1'b0; Zlowout = 1'b0;
    PCout = 1'b0; MDRout = 1'b0; INout = 1'b0; Cout = 1'b0;
    HIin = 1'b0; LOin = 1'b0; PCin = 1'b0; IRin = 1'b0; Zin = 1'b0;
    Yin = 1'b0; MARin = 1'b0; MDRin = 1'b0; CONin = 1'b0; OUT_Portin = 1'b0;
    Read = 1'b0; read_mem = 1'b0; write_mem = 1'b0; IncPC = 1'b0;
    PCSave = 1'b0; CON_RESET = 1'b0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
    alu_s = '0;
    Run = (state_q != S_RST) && (state_q != S_HALT);
    case (state_q)
      S_RST: CON_RESET = 1'b1;
      S_T0: begin IncPC = 1'b1; PCin = 1'b1; MARin = 1'b1; end
      S_T1: begin MDRin = 1'b1; Read = 1'b1; read_mem = 1'b1; end
      S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      S_T3: begin
        case (op_s)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL,
          OP_ADDI, OP_ANDI, OP_ORI: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          OP_LDI, OP_LD, OP_ST:     begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
          OP_MUL, OP_DIV:           begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          OP_NEG, OP_NOT: begin
            Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_s = alu_for(op_s);
          end
          OP_BR:   begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
          OP_JR:   begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
          OP_JAL:  PCSave = 1'b1;
          OP_IN:   begin INout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          OP_OUT:  begin Gra = 1'b1; Rout = 1'b1; OUT_Portin = 1'b1; end
          OP_MFHI: begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          OP_MFLO: begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          default: ;
        endcase
      end
      S_T4: begin
        case (op_s)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL: begin
            Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_s = alu_for(op_s);
          end
          OP_ADDI, OP_ANDI, OP_ORI: begin
            Cout = 1'b1; Zin = 1'b1; alu_s = alu_for(op_s);
          end
          OP_LDI, OP_LD, OP_ST: begin Cout = 1'b1; Zin = 1'b1; alu_s.add_op = 1'b1; end
          OP_MUL, OP_DIV: begin
            Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_s = alu_for(op_s);
          end
          OP_NEG, OP_NOT: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          OP_BR:          begin PCout = 1'b1; Yin = 1'b1; end
          OP_JAL:         begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
          default: ;
        endcase
      end
      S_T5: begin
        case (op_s)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL,
          OP_ADDI, OP_ANDI, OP_ORI, OP_LDI: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          OP_LD, OP_ST:   begin Zlowout = 1'b1; MARin = 1'b1; end
          OP_MUL, OP_DIV: begin Zlowout = 1'b1; LOin = 1'b1; end
          OP_BR:          begin Cout = 1'b1; Zin = 1'b1; alu_s.add_op = 1'b1; end
          default: ;
        endcase
      end
      S_T6: begin
        case (op_s)
          OP_LD:          begin Read = 1'b1; read_mem = 1'b1; MDRin = 1'b1; end
          OP_ST:          begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
          OP_MUL, OP_DIV: begin Zhighout = 1'b1; HIin = 1'b1; end
          OP_BR: begin
            // Branch taken only when the condition flip-flop is set.
            if (CON_FF) begin
              PCin = 1'b1; Zlowout = 1'b1;
            end else begin
              PCin = 1'b0; Zlowout = 1'b0;
            end
          end
          default: ;
        endcase
      end
      S_T7: begin
        case (op_s)
          OP_LD:   begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          OP_ST:   write_mem = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign AND  = alu_s.and_op;
  assign OR   = alu_s.or_op;
  assign ADD  = alu_s.add_op;
  assign SUB  = alu_s.sub_op;
  assign MUL  = alu_s.mul_op;
  assign DIV  = alu_s.div_op;
  assign SHR  = alu_s.shr_op;
  assign SHRA = alu_s.shra_op;
  assign SHL  = alu_s.shl_op;
  assign ROR  = alu_s.ror_op;
  assign ROL  = alu_s.rol_op;
  assign NEG  = alu_s.neg_op;
  assign NOT  = alu_s.not_op;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: per-instruction T-state strobe tables plus
// hand-written reset and halt sequences, checked through an expectation queue.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] IR;
  logic        CON_FF;
  logic HIout, LOout, Zhighout, Zlowout, PCout, MDRout, INout, Cout;
  logic HIin, LOin, PCin, IRin, Zin, Yin, MARin, MDRin, CONin, OUT_Portin;
  logic Read, read_mem, write_mem, IncPC, PCSave, CON_RESET;
  logic AND, OR, ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, NEG, NOT;
  logic Gra, Grb, Grc, Rin, Rout, BAout, Run;

  control_sequencer #(.OPW(5)) dut (
    .clk(clk), .reset(reset), .IR(IR), .CON_FF(CON_FF),
    .HIout(HIout), .LOout(LOout), .Zhighout(Zhighout), .Zlowout(Zlowout),
    .PCout(PCout), .MDRout(MDRout), .INout(INout), .Cout(Cout),
    .HIin(HIin), .LOin(LOin), .PCin(PCin), .IRin(IRin), .Zin(Zin), .Yin(Yin),
    .MARin(MARin), .MDRin(MDRin), .CONin(CONin), .OUT_Portin(OUT_Portin),
    .Read(Read), .read_mem(read_mem), .write_mem(write_mem), .IncPC(IncPC),
    .PCSave(PCSave), .CON_RESET(CON_RESET),
    .AND(AND), .OR(OR), .ADD(ADD), .SUB(SUB), .MUL(MUL), .DIV(DIV), .SHR(SHR),
    .SHRA(SHRA), .SHL(SHL), .ROR(ROR), .ROL(ROL), .NEG(NEG), .NOT(NOT),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .Run(Run)
  );

  always #5 clk = ~clk;

  logic [43:0] obs;
  assign obs = {HIout, LOout, Zhighout, Zlowout, PCout, MDRout, INout, Cout,
                HIin, LOin, PCin, IRin, Zin, Yin, MARin, MDRin, CONin, OUT_Portin,
                Read, read_mem, write_mem, IncPC, PCSave, CON_RESET,
                AND, OR, ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, NEG, NOT,
                Gra, Grb, Grc, Rin, Rout, BAout, Run};

  localparam logic [43:0] HIOUT = 44'd1 << 43, LOOUT = 44'd1 << 42, ZHI = 44'd1 << 41,
    ZLO = 44'd1 << 40, PCOUT = 44'd1 << 39, MDROUT = 44'd1 << 38, INOUT = 44'd1 << 37,
    COUT = 44'd1 << 36, HIIN = 44'd1 << 35, LOIN = 44'd1 << 34, PCIN = 44'd1 << 33,
    IRIN = 44'd1 << 32, ZIN = 44'd1 << 31, YIN = 44'd1 << 30, MARIN = 44'd1 << 29,
    MDRIN = 44'd1 << 28, CONIN = 44'd1 << 27, OUTP = 44'd1 << 26, READ = 44'd1 << 25,
    RMEM = 44'd1 << 24, WMEM = 44'd1 << 23, INCPC = 44'd1 << 22, PCSAVE = 44'd1 << 21,
    CONRST = 44'd1 << 20, A_AND = 44'd1 << 19, A_OR = 44'd1 << 18, A_ADD = 44'd1 << 17,
    A_SHRA = 44'd1 << 12, A_MUL = 44'd1 << 15, A_DIV = 44'd1 << 14, A_NOT = 44'd1 << 7,
    GRA = 44'd1 << 6, GRB = 44'd1 << 5, GRC = 44'd1 << 4, RIN = 44'd1 << 3,
    ROUT = 44'd1 << 2, BAOUT = 44'd1 << 1, RUN = 44'd1;

  localparam logic [43:0] F0 = INCPC | PCIN | MARIN | RUN;
  localparam logic [43:0] F1 = MDRIN | READ | RMEM | RUN;
  localparam logic [43:0] F2 = MDROUT | IRIN | RUN;

  typedef struct packed {
    logic [31:0]      ir;
    logic             con_ff;
    logic [3:0]       ncyc;
    logic [7:0][43:0] exp;
  } vec_t;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [43:0] exp_q[$];
  vec_t  tbl[19];
  string nm[19];

  function automatic vec_t mk(input logic [31:0] ir, input logic c, input logic [3:0] n,
                              input logic [43:0] e3, input logic [43:0] e4,
                              input logic [43:0] e5, input logic [43:0] e6,
                              input logic [43:0] e7);
    vec_t v;
    v.ir = ir; v.con_ff = c; v.ncyc = n;
    v.exp[0] = F0; v.exp[1] = F1; v.exp[2] = F2;
    v.exp[3] = e3 | RUN; v.exp[4] = e4 | RUN; v.exp[5] = e5 | RUN;
    v.exp[6] = e6 | RUN; v.exp[7] = e7 | RUN;
    return v;
  endfunction

  task automatic check(input string name, input logic [43:0] act, input logic [43:0] want);
    total_cnt++;
    if (act !== want) begin
      $display("FAIL %s: got %011h expected %011h", name, act, want);
    end else begin
      pass_cnt++;
    end
  endtask

  // Wait to the next falling edge and compare against the oldest expectation.
  task automatic expect_cycle(input string name);
    logic [43:0] want;
    @(negedge clk);
    want = exp_q.pop_front();
    check(name, obs, want);
  endtask

  // Enter T0 on the next rising edge, present the instruction, check each step.
  task automatic run_vec(input vec_t v, input string name);
    @(posedge clk);
    #1;
    IR = v.ir;
    CON_FF = v.con_ff;
    for (int c = 0; c < int'(v.ncyc); c++) exp_q.push_back(v.exp[c]);
    for (int c = 0; c < int'(v.ncyc); c++) expect_cycle($sformatf("%s_T%0d", name, c));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = mk(32'h69200053, 1'b0, 4'd6, GRB|ROUT|YIN, COUT|A_AND|ZIN, ZLO|GRA|RIN, 44'd0, 44'd0);
    nm[0] = "andi";
    tbl[1]  = mk(32'h00900054, 1'b0, 4'd8, GRB|BAOUT|YIN, COUT|A_ADD|ZIN, ZLO|MARIN,
                 READ|RMEM|MDRIN, MDROUT|GRA|RIN);
    nm[1] = "ld";
    tbl[2]  = mk(32'h9A800019, 1'b1, 4'd7, GRA|ROUT|CONIN, PCOUT|YIN, COUT|A_ADD|ZIN, PCIN|ZLO, 44'd0);
    nm[2] = "br_taken";
    tbl[3]  = mk(32'h9A800019, 1'b0, 4'd7, GRA|ROUT|CONIN, PCOUT|YIN, COUT|A_ADD|ZIN, 44'd0, 44'd0);
    nm[3] = "br_not_taken";
    tbl[4]  = mk(32'h79A00000, 1'b0, 4'd7, GRA|ROUT|YIN, GRB|ROUT|A_MUL|ZIN, ZLO|LOIN, ZHI|HIIN, 44'd0);
    nm[4] = "mul";
    tbl[5]  = mk(32'h18000000, 1'b0, 4'd6, GRB|ROUT|YIN, GRC|ROUT|A_ADD|ZIN, ZLO|GRA|RIN, 44'd0, 44'd0);
    nm[5] = "add";
    tbl[6]  = mk(32'h10000000, 1'b0, 4'd8, GRB|BAOUT|YIN, COUT|A_ADD|ZIN, ZLO|MARIN,
                 GRA|ROUT|MDRIN, WMEM);
    nm[6] = "st";
    tbl[7]  = mk(32'h08000000, 1'b0, 4'd6, GRB|BAOUT|YIN, COUT|A_ADD|ZIN, ZLO|GRA|RIN, 44'd0, 44'd0);
    nm[7] = "ldi";
    tbl[8]  = mk(32'h50000000, 1'b0, 4'd6, GRB|ROUT|YIN, GRC|ROUT|A_SHRA|ZIN, ZLO|GRA|RIN, 44'd0, 44'd0);
    nm[8] = "shra";
    tbl[9]  = mk(32'h80000000, 1'b1, 4'd7, GRA|ROUT|YIN, GRB|ROUT|A_DIV|ZIN, ZLO|LOIN, ZHI|HIIN, 44'd0);
    nm[9] = "div";
    tbl[10] = mk(32'h90000000, 1'b0, 4'd5, GRB|ROUT|A_NOT|ZIN, ZLO|GRA|RIN, 44'd0, 44'd0, 44'd0);
    nm[10] = "not";
    tbl[11] = mk(32'hA8000000, 1'b0, 4'd5, PCSAVE, GRA|ROUT|PCIN, 44'd0, 44'd0, 44'd0);
    nm[11] = "jal";
    tbl[12] = mk(32'hA0000000, 1'b0, 4'd4, GRA|ROUT|PCIN, 44'd0, 44'd0, 44'd0, 44'd0);
    nm[12] = "jr";
    tbl[13] = mk(32'hB8000000, 1'b0, 4'd4, GRA|ROUT|OUTP, 44'd0, 44'd0, 44'd0, 44'd0);
    nm[13] = "out";
    tbl[14] = mk(32'hC8000000, 1'b0, 4'd4, LOOUT|GRA|RIN, 44'd0, 44'd0, 44'd0, 44'd0);
    nm[14] = "mflo";
    tbl[15] = mk(32'hB0000000, 1'b0, 4'd4, INOUT|GRA|RIN, 44'd0, 44'd0, 44'd0, 44'd0);
    nm[15] = "in";
    tbl[16] = mk(32'hD0000000, 1'b0, 4'd3, 44'd0, 44'd0, 44'd0, 44'd0, 44'd0);
    nm[16] = "nop";
    tbl[17] = mk(32'hF8000000, 1'b0, 4'd3, 44'd0, 44'd0, 44'd0, 44'd0, 44'd0);
    nm[17] = "reserved";
    tbl[18] = mk(32'h70000000, 1'b1, 4'd6, GRB|ROUT|YIN, COUT|A_OR|ZIN, ZLO|GRA|RIN, 44'd0, 44'd0);
    nm[18] = "ori";

    // Power-up reset held for three cycles.
    reset = 1'b0;
    IR = 32'h0;
    CON_FF = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(CONRST);
      expect_cycle($sformatf("reset_hold_%0d", i));
    end
    reset = 1'b1;

    for (int i = 0; i < 19; i++) run_vec(tbl[i], nm[i]);

    // Reset asserted in T4 of an add: strobes drop without a clock edge.
    @(posedge clk);
    #1;
    IR = 32'h18000000;
    CON_FF = 1'b0;
    exp_q.push_back(F0); exp_q.push_back(F1); exp_q.push_back(F2);
    exp_q.push_back(GRB|ROUT|YIN|RUN); exp_q.push_back(GRC|ROUT|A_ADD|ZIN|RUN);
    for (int c = 0; c < 5; c++) expect_cycle($sformatf("add_pre_reset_T%0d", c));
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_mid_add", obs, CONRST);
    exp_q.push_back(CONRST);
    expect_cycle("async_reset_held");
    reset = 1'b1;
    run_vec(tbl[0], "andi_after_reset");

    // Halt: fetch, then twenty silent cycles, then a reset pulse restarts at T0.
    @(posedge clk);
    #1;
    IR = 32'hD8000000;
    exp_q.push_back(F0); exp_q.push_back(F1); exp_q.push_back(F2);
    for (int c = 0; c < 3; c++) expect_cycle($sformatf("halt_T%0d", c));
    for (int c = 0; c < 20; c++) begin
      exp_q.push_back(44'd0);
      expect_cycle($sformatf("halted_%0d", c));
    end
    #2;
    reset = 1'b0;
    #1;
    check("halt_reset_pulse", obs, CONRST);
    @(negedge clk);
    reset = 1'b1;
    run_vec(tbl[5], "add_after_halt");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
